idex_elastic_reg: RTL

//  Parametrised ID->EX pipeline register with valid/ready handshake, a 2-entry skid buffer and flush.

---
 rtl/idex_pkg.sv | 25 ++
 rtl/idex_sat_cnt.sv | 22 ++
 rtl/idex_elastic_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/idex_pkg.sv
// Shared ID/EX control-bundle layout and payload sizing, used by decoder, this register and EX.
package idex_pkg;
  localparam int ALUOP_W_DEF    = 5;
  localparam int CTRL_FLAGS     = 9;
  localparam int CTRL_ALUOP_LSB = 0;
  // Flag bit indices for the default ALUOP_W; flags sit directly above alu_op.
  localparam int CTRL_LD        = ALUOP_W_DEF + 0;
  localparam int CTRL_JR        = ALUOP_W_DEF + 1;
  localparam int CTRL_JUMP      = ALUOP_W_DEF + 2;
  localparam int CTRL_ALUSRC    = ALUOP_W_DEF + 3;
  localparam int CTRL_REGDST    = ALUOP_W_DEF + 4;
  localparam int CTRL_MEMWRITE  = ALUOP_W_DEF + 5;
  localparam int CTRL_BRANCH    = ALUOP_W_DEF + 6;
  localparam int CTRL_MEMTOREG  = ALUOP_W_DEF + 7;
  localparam int CTRL_REGWRITE  = ALUOP_W_DEF + 8;
  localparam int CTRL_W         = CTRL_FLAGS + ALUOP_W_DEF;

  function automatic int ctrl_w(input int aluop_w);
    return CTRL_FLAGS + aluop_w;
  endfunction

  function automatic int payload_w(input int cw, input int pc_w, input int data_w, input int reg_aw);
    return cw + pc_w + 3 * data_w + 4 * reg_aw;
  endfunction
endpackage

// File: rtl/idex_sat_cnt.sv
// Saturating up-counter for perf debug; sticks at all-ones.
module idex_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/idex_elastic_reg.sv
// ID->EX elastic pipeline register: main + skid entry, flush, saturating stall/flush counters.
module idex_elastic_reg import idex_pkg::*; #(
  parameter  int DATA_W  = 32,
  parameter  int REG_AW  = 5,
  parameter  int ALUOP_W = 5,
  parameter  int PC_W    = 8,
  parameter  int CNT_W   = 16,
  localparam int CTRL_W  = ctrl_w(ALUOP_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pcadd,
  input  logic [DATA_W-1:0] in_r1,
  input  logic [DATA_W-1:0] in_r2,
  input  logic [DATA_W-1:0] in_signimm,
  input  logic [REG_AW-1:0] in_rd1,
  input  logic [REG_AW-1:0] in_rd2,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [PC_W-1:0]   idex_pcadd,
  output logic [DATA_W-1:0] idex_r1,
  output logic [DATA_W-1:0] idex_r2,
  output logic [DATA_W-1:0] idex_signimm,
  output logic [REG_AW-1:0] idex_rd1,
  output logic [REG_AW-1:0] idex_rd2,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam int PW = payload_w(CTRL_W, PC_W, DATA_W, REG_AW);

  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic [CTRL_W-1:0] main_ctrl;
  logic          in_fire, out_fire;

  assign in_pl    = {in_ctrl, in_pcadd, in_r1, in_r2, in_signimm, in_rd1, in_rd2, in_rs, in_rt};
  // Ready comes straight from a flop, so no input reaches it combinationally.
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    unique case ({main_valid_q, skid_valid_q})
      2'b00: if (in_fire) begin
        main_d       = in_pl;
        main_valid_d = 1'b1;
      end
      2'b10: begin
        if (in_fire && out_fire) main_d = in_pl;
        else if (in_fire) begin
          skid_d       = in_pl;
          skid_valid_d = 1'b1;
        end else if (out_fire) main_valid_d = 1'b0;
      end
      2'b11: if (out_fire) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
      default: ;
    endcase
    // Flush wins over every handshake; payload keeps its old contents.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_d       = main_q;
      skid_d       = skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end

  assign {main_ctrl, idex_pcadd, idex_r1, idex_r2, idex_signimm,
          idex_rd1, idex_rd2, idex_rs, idex_rt} = main_q;
  assign out_valid = main_valid_q;
  assign idex_ctrl = main_valid_q ? main_ctrl : '0;

  idex_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(main_valid_q & ~out_ready), .cnt(stall_cnt));

  idex_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush & (main_valid_q | skid_valid_q)), .cnt(flush_cnt));

  a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst_n)
    main_valid_q || !skid_valid_q);
endmodule
